// File: rtl/digit_scan_mux.sv
// Time-multiplexed N-digit seven-segment scanner with per-digit blank/blink,
// 8-level in-slot brightness, a ghosting guard cycle and a frame-start strobe.
module digit_scan_mux #(
  parameter int               NUM_DIGITS        = 4,
  parameter int               SEG_W             = 8,
  parameter int               TICK_DIV          = 50000,
  parameter int               BLINK_DIV         = 128,
  parameter logic [SEG_W-1:0] SEG_OFF           = 8'hFF,
  parameter bit               ENABLE_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic [2:0]                  brightness,
  output logic [SEG_W-1:0]            out,
  output logic [NUM_DIGITS-1:0]       enable,
  output logic                        frame_start
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int SW   = $clog2(NUM_DIGITS);
  localparam int FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int UNIT = TICK_DIV / 8;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = ENABLE_ACTIVE_LOW ? '1 : '0;

  logic [TW-1:0]         tick_q, tick_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_off_q, blink_off_d;
  logic [2:0]            bright_q, bright_d;
  logic                  frame_pend_q, frame_pend_d;
  logic [SEG_W-1:0]      out_q, out_d;
  logic [NUM_DIGITS-1:0] enable_q, enable_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick_wrap, slot_wrap, frame_wrap;
  logic [SEG_W-1:0]      seg_sel;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  dark;
  logic [TW:0]           on_len;
  logic                  lit;

  // Scan counters: tick within slot, slot within frame, frame within blink phase.
  always_comb begin
    tick_wrap  = (tick_q == TW'(TICK_DIV - 1));
    slot_wrap  = tick_wrap && (slot_q == SW'(NUM_DIGITS - 1));
    frame_wrap = slot_wrap && (frame_q == FW'(BLINK_DIV - 1));

    tick_d = tick_wrap ? '0 : tick_q + 1'b1;

    slot_d = slot_q;
    if (tick_wrap) slot_d = slot_wrap ? '0 : slot_q + 1'b1;

    frame_d = frame_q;
    if (slot_wrap) frame_d = frame_wrap ? '0 : frame_q + 1'b1;

    blink_off_d  = blink_off_q ^ frame_wrap;
    bright_d     = tick_wrap ? brightness : bright_q;
    // High exactly while the counters sit on slot 0 tick 0 after a real wrap.
    frame_pend_d = slot_wrap;
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    seg_sel = SEG_OFF;
    onehot  = '0;
    dark    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SW'(i)) begin
        seg_sel   = digits_in[i*SEG_W +: SEG_W];
        onehot[i] = 1'b1;
        dark      = blank_mask[i] | (blink_mask[i] & blink_off_q);
      end
    end

    on_len = (TW + 1)'((32'(bright_q) + 32'd1) * 32'(UNIT));
    lit    = (tick_q != '0) && ({1'b0, tick_q} < on_len) && !dark;

    out_d         = lit ? seg_sel : SEG_OFF;
    enable_d      = lit ? (ENABLE_ACTIVE_LOW ? ~onehot : onehot) : EN_OFF;
    frame_start_d = frame_pend_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; rst is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q        <= '0;
      slot_q        <= '0;
      frame_q       <= '0;
      blink_off_q   <= 1'b0;
      bright_q      <= 3'd7;
      frame_pend_q  <= 1'b0;
      out_q         <= SEG_OFF;
      enable_q      <= EN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      slot_q        <= slot_d;
      frame_q       <= frame_d;
      blink_off_q   <= blink_off_d;
      bright_q      <= bright_d;
      frame_pend_q  <= frame_pend_d;
      out_q         <= out_d;
      enable_q      <= enable_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign out         = out_q;
  assign enable      = enable_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux: a 4-digit active-low instance and a
// 6-digit active-high instance run side by side against a cycle-index model.
module tb_digit_scan_mux;

  localparam int TICK  = 8;
  localparam int BLINK = 2;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] en;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  brightness = 3'd7;
  logic [31:0] digits_a = 32'h44332211;
  logic [3:0]  blank_a = '0, blink_a = '0;
  logic [47:0] digits_b = 48'h665544332211;
  logic [5:0]  blank_b = '0, blink_b = '0;
  logic [7:0]  out_a, out_b;
  logic [3:0]  en_a;
  logic [5:0]  en_b;
  logic        fs_a, fs_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   k = 0;       // cycles of scanning since reset release (counter state index)
  int   bright = 7;  // brightness level governing the current slot
  int   obs_k = 0;   // state index the just-sampled outputs reflect
  exp_t exp_a, exp_b;

  always #5 clk = ~clk;

  digit_scan_mux #(.NUM_DIGITS(4), .SEG_W(8), .TICK_DIV(TICK), .BLINK_DIV(BLINK),
                   .SEG_OFF(8'hFF), .ENABLE_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .digits_in(digits_a), .blank_mask(blank_a),
    .blink_mask(blink_a), .brightness(brightness), .out(out_a), .enable(en_a),
    .frame_start(fs_a));

  digit_scan_mux #(.NUM_DIGITS(6), .SEG_W(8), .TICK_DIV(TICK), .BLINK_DIV(BLINK),
                   .SEG_OFF(8'hFF), .ENABLE_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .digits_in(digits_b), .blank_mask(blank_b),
    .blink_mask(blink_b), .brightness(brightness), .out(out_b), .enable(en_b),
    .frame_start(fs_b));

  // Expected registered outputs for counter state index kk, from the display rules.
  function automatic exp_t model(int n, bit act_low, int kk, int br, logic [63:0] digs,
                                 logic [7:0] blank, logic [7:0] blink, bit in_rst);
    int   tick, slot, frame;
    bit   boff, lit;
    logic [7:0] oh;
    exp_t e;
    tick  = kk % TICK;
    slot  = (kk / TICK) % n;
    frame = kk / (TICK * n);
    boff  = ((frame / BLINK) % 2) == 1;
    lit   = !in_rst && tick != 0 && tick < (br + 1) * (TICK / 8)
            && !blank[slot] && !(blink[slot] && boff);
    oh    = lit ? (8'd1 << slot) : 8'd0;
    e.seg = lit ? digs[slot*8 +: 8] : 8'hFF;
    e.en  = act_low ? ~oh : oh;
    e.fs  = !in_rst && tick == 0 && slot == 0 && kk > 0;
    return e;
  endfunction

  // Predict the next edge, clock it, and advance the model state.
  task automatic advance();
    bit r;
    int tnow, bin;
    r    = rst;
    tnow = k % TICK;
    bin  = int'(brightness);
    exp_a = model(4, 1'b1, k, bright, {32'h0, digits_a}, {4'h0, blank_a}, {4'h0, blink_a}, r);
    exp_b = model(6, 1'b0, k, bright, {16'h0, digits_b}, {2'h0, blank_b}, {2'h0, blink_b}, r);
    obs_k = k;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      bright = 7;
    end else begin
      if (tnow == TICK - 1) bright = bin;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      vectors++;
      if ({out_a, en_a, fs_a, out_b, en_b, fs_b} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 6'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_values got a=%h/%b/%b b=%h/%b/%b exp a=ff/1111/0 b=ff/000000/0",
                 out_a, en_a, fs_a, out_b, en_b, fs_b);
      end
    end
  endtask

  task automatic test_basic_scan();
    int d0_cnt = 0, fs_cnt = 0, fs_b_first = -1;
    digits_a = 32'h44332211; brightness = 3'd7;
    blank_a = '0; blink_a = '0; blank_b = '0; blink_b = '0;
    rst = 1'b0;
    for (int i = 0; i < 96; i++) begin
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL basic_a k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
      vectors++;
      if ({out_b, en_b, fs_b} !== {exp_b.seg, exp_b.en[5:0], exp_b.fs}) begin
        miscompares++;
        $display("FAIL basic_b k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_b, en_b, fs_b,
                 exp_b.seg, exp_b.en[5:0], exp_b.fs);
      end
      if (en_a === 4'b1110 && out_a === 8'h11) d0_cnt++;
      if (fs_a === 1'b1) fs_cnt++;
      if (fs_b === 1'b1 && fs_b_first < 0) fs_b_first = obs_k;
    end
    vectors++;
    if (d0_cnt !== 21 || fs_cnt !== 2) begin
      miscompares++;
      $display("FAIL basic_counts digit0_lit=%0d frame_starts=%0d exp 21 and 2", d0_cnt, fs_cnt);
    end
    vectors++;
    if (fs_b_first !== 48) begin
      miscompares++;
      $display("FAIL six_digit_frame first frame_start at k=%0d exp 48", fs_b_first);
    end
  endtask

  task automatic test_dimming();
    int lit_a = 0, lit_b = 0, off_tick = 0;
    brightness = 3'd1;
    do_reset();
    for (int i = 0; i < 72; i++) begin
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL dim_a k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
      vectors++;
      if ({out_b, en_b, fs_b} !== {exp_b.seg, exp_b.en[5:0], exp_b.fs}) begin
        miscompares++;
        $display("FAIL dim_b k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_b, en_b, fs_b,
                 exp_b.seg, exp_b.en[5:0], exp_b.fs);
      end
      if (obs_k >= 8) begin
        if (en_a !== 4'hF) lit_a++;
        if (en_b !== 6'h0) lit_b++;
        if (en_a !== 4'hF && (obs_k % TICK) != 1) off_tick++;
      end
    end
    vectors++;
    if (lit_a !== 8 || lit_b !== 8 || off_tick !== 0) begin
      miscompares++;
      $display("FAIL dim_counts lit_a=%0d lit_b=%0d lit_outside_tick1=%0d exp 8/8/0",
               lit_a, lit_b, off_tick);
    end
  endtask

  task automatic test_midslot_brightness();
    int lit_s1 = 0, lit_s2 = 0;
    brightness = 3'd7;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (k == 11) brightness = 3'd0;
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL midslot_a k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
      if (obs_k >= 11 && obs_k <= 15 && en_a === 4'b1101) lit_s1++;
      if (obs_k >= 16 && en_a !== 4'hF) lit_s2++;
    end
    vectors++;
    if (lit_s1 !== 5 || lit_s2 !== 0) begin
      miscompares++;
      $display("FAIL midslot_counts slot1_tail_lit=%0d slot2_lit=%0d exp 5/0", lit_s1, lit_s2);
    end
    brightness = 3'd7;
  endtask

  task automatic test_blank_blink();
    int d2 = 0, d0_f01 = 0, d0_f23 = 0, d0_f4 = 0;
    blank_a = 4'b0100; blink_a = 4'b0001;
    blank_b = 6'b001000; blink_b = 6'b000010;
    do_reset();
    for (int i = 0; i < 160; i++) begin
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL blink_a k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
      vectors++;
      if ({out_b, en_b, fs_b} !== {exp_b.seg, exp_b.en[5:0], exp_b.fs}) begin
        miscompares++;
        $display("FAIL blink_b k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_b, en_b, fs_b,
                 exp_b.seg, exp_b.en[5:0], exp_b.fs);
      end
      if (en_a[2] === 1'b0) d2++;
      if (en_a === 4'b1110) begin
        if (obs_k < 64) d0_f01++;
        else if (obs_k < 128) d0_f23++;
        else d0_f4++;
      end
    end
    vectors++;
    if (d2 !== 0 || d0_f01 !== 14 || d0_f23 !== 0 || d0_f4 !== 7) begin
      miscompares++;
      $display("FAIL blink_counts digit2=%0d d0_f01=%0d d0_f23=%0d d0_f4=%0d exp 0/14/0/7",
               d2, d0_f01, d0_f23, d0_f4);
    end
    blank_a = '0; blink_a = '0; blank_b = '0; blink_b = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL rmid_run k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
    end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    vectors++;
    if ({out_a, en_a, fs_a, en_b} !== {8'hFF, 4'hF, 1'b0, 6'h0}) begin
      miscompares++;
      $display("FAIL rmid_reset got %h/%b/%b b_en=%b exp ff/1111/0 b_en=000000",
               out_a, en_a, fs_a, en_b);
    end
    advance();
    vectors++;
    if ({out_a, en_a, fs_a} !== {8'hFF, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid_guard got %h/%b/%b exp ff/1111/0", out_a, en_a, fs_a);
    end
    advance();
    vectors++;
    if ({out_a, en_a, fs_a} !== {digits_a[7:0], 4'b1110, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid_first_lit got %h/%b/%b exp %h/1110/0", out_a, en_a, fs_a,
               digits_a[7:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_a = $urandom();
        digits_b = 48'({$urandom(), $urandom()});
        blank_a  = 4'($urandom());
        blink_a  = 4'($urandom());
        blank_b  = 6'($urandom());
        blink_b  = 6'($urandom());
      end
      if ($urandom_range(0, 7) == 0) brightness = 3'($urandom());
      rst = ($urandom_range(0, 63) == 0);
      advance();
      vectors++;
      if ({out_a, en_a, fs_a} !== {exp_a.seg, exp_a.en[3:0], exp_a.fs}) begin
        miscompares++;
        $display("FAIL random_a k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_a, en_a, fs_a,
                 exp_a.seg, exp_a.en[3:0], exp_a.fs);
      end
      vectors++;
      if ({out_b, en_b, fs_b} !== {exp_b.seg, exp_b.en[5:0], exp_b.fs}) begin
        miscompares++;
        $display("FAIL random_b k=%0d got %h/%b/%b exp %h/%b/%b", obs_k, out_b, en_b, fs_b,
                 exp_b.seg, exp_b.en[5:0], exp_b.fs);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_basic_scan();
    test_dimming();
    test_midslot_brightness();
    test_blank_blink();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
Parametrised time-multiplexed driver for common-enable seven-segment displays, generalising the fixed 4-digit scanner to N digits. It adds several features:
- per-digit blanking and blinking
- 8-level brightness via in-slot duty cycle
- a ghosting guard cycle between digits
- a frame-start strobe

It sits between the display-formatting logic (segment encoders) and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 2..8)
SEG_W, 8, segment bus width per digit (7 segments + dp)
TICK_DIV, 50000, clk cycles each digit slot lasts; must be a multiple of 8, >= 8
BLINK_DIV, 128, completed scan frames per blink half-period (>= 1)
SEG_OFF, 8'hFF, value driven on out when no digit is lit (active-low segments)
ENABLE_ACTIVE_LOW, 1, 1: enable bit 0 = digit on; 0: enable bit 1 = digit on

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
digits_in  in  NUM_DIGITS*SEG_W  digit i segments at [i*SEG_W +: SEG_W]
blank_mask  in  NUM_DIGITS  1 = digit i permanently dark
blink_mask  in  NUM_DIGITS  1 = digit i dark during blink-off phase
brightness  in  3  on-time level 0..7
out  out  SEG_W  segment pattern of currently lit digit
enable  out  NUM_DIGITS  one-hot digit enable (polarity per ENABLE_ACTIVE_LOW)
frame_start  out  1  one-clk strobe at start of each frame

Behaviour:
- Internal state:
  - tick_cnt: 0..TICK_DIV-1, increments every clk.
  - slot: 0..NUM_DIGITS-1, advances when tick_cnt wraps; wraps NUM_DIGITS-1 -> 0.
  - frame_cnt: 0..BLINK_DIV-1, increments on each slot wrap to 0.
  - blink_off: toggles when frame_cnt wraps.
  - bright_q: latched brightness.
- brightness is sampled into bright_q only when tick_cnt wraps (slot boundary). Mid-slot changes take effect from the next slot; there is no partial-slot glitch.
- on_len = (bright_q+1)*(TICK_DIV/8).
- Digit in current slot is lit iff all of the following hold:
  - tick_cnt != 0 (ghosting guard cycle)
  - tick_cnt < on_len
  - blank_mask[slot] == 0
  - !(blink_mask[slot] && blink_off)
- Lit duration per slot = on_len-1 cycles; at brightness 7 this is TICK_DIV-1.
- Outputs are registered; latency 1 clk.
  - The output in cycle t reflects counter state and inputs in cycle t-1.
  - digits_in and masks are sampled continuously (not latched per slot).
- When lit:
  - out = digits_in[slot]
  - enable has only bit slot active
- When not lit: out = SEG_OFF, all enable bits inactive.
- At most one enable bit is active in any cycle; there is never an active enable during a slot's first (guard) cycle.
- frame_start:
  - High for exactly one clk, coincident with the guard cycle output of slot 0.
  - Asserted only on a wrap from slot NUM_DIGITS-1 to 0, never for the first frame after reset.
- Reset (synchronous, any time, including mid-slot) produces these values on the next clk edge:
  - tick_cnt=0, slot=0, frame_cnt=0, blink_off=0, bright_q=7
  - out=SEG_OFF, enable all inactive, frame_start=0
- Resumption after rst deasserts:
  - Scanning restarts at slot 0, tick 0.
  - The first lit cycle is 2 clks after the first clk with rst low (counter cycle plus output register).
- Reset held: outputs stay at reset values and counters stay frozen at 0.
- Brightness 7 with TICK_DIV=8 still gives the guard cycle, so the digit is lit 7 of 8 cycles.
- Simultaneous slot wrap and frame_cnt wrap in the same clk:
  - blink_off toggles.
  - The new phase applies from that frame's slot 0 guard cycle onward.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLINK_DIV=2, ENABLE_ACTIVE_LOW=1.
- Basic scan: digits 0x11/0x22/0x33/0x44, brightness=7, masks 0 -> per 8-clk slot: 1 guard cycle (enable=1111, out=FF) then 7 cycles of enable 1110/out 11, 1101/22, 1011/33, 0111/44 in order; frame_start high one clk at each slot-0 guard except the first.
- Dimming: brightness=1 (on_len=2) -> each slot lit exactly 1 clk (tick 1), other 7 clks enable=1111, out=FF.
- Mid-slot brightness change: change brightness 7->0 at tick 3 of slot 1 -> slot 1 stays lit through tick 7; slot 2 lit only 0 cycles (on_len=1) -> enable=1111 whole slot.
- Blank/blink: blank_mask=0100, blink_mask=0001 -> digit 2 never enabled; digit 0 lit in frames 0-1, dark in frames 2-3 (cycles 64..127), lit again from frame 4.
- Reset mid-operation: assert rst for 1 clk at tick 4 of slot 2 -> next edge out=FF, enable=1111, frame_start=0; scan resumes at slot 0 with guard, enable=1110 two clks after rst low, no frame_start for this restart.
- Polarity and width: ENABLE_ACTIVE_LOW=0, NUM_DIGITS=6 -> enables one-hot active-high 000001..100000, all-zero during guard/dark cycles, full frame = 48 clks.
